// File: rtl/sifh_ctrl.sv
// Two-pass histogram peak finder for TDC timestamps: a coarse pass locates the busiest
// upper-bit bin, then a fine pass histograms the lower bits inside that coarse bin.
module sifh_ctrl #(
    parameter int NP        = 10,
    parameter int RAM_ADDR  = 6,
    parameter int CNT_W     = 8,
    parameter int N_SAMPLES = 16
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                data_valid,
    input  logic [NP-1:0]       data,
    input  logic [CNT_W-1:0]    counts,
    output logic [RAM_ADDR-1:0] waddr,
    output logic [RAM_ADDR-1:0] raddr,
    output logic                wEnable,
    output logic                rEnable,
    output logic                writeFlag,
    output logic                readFlag,
    output logic [CNT_W-1:0]    newCounts,
    output logic                busy,
    output logic                done,
    output logic [NP-1:0]       result,
    output logic [CNT_W-1:0]    peak_count
);

    localparam int FW   = NP - RAM_ADDR;
    localparam int BINS = 2 ** RAM_ADDR;
    localparam int SW   = $clog2(N_SAMPLES + 1);
    localparam logic [RAM_ADDR-1:0] LAST_ADDR = {RAM_ADDR{1'b1}};
    localparam logic [RAM_ADDR:0]   RD_LAST   = (RAM_ADDR+1)'(BINS - 1);
    localparam logic [RAM_ADDR:0]   RD_END    = (RAM_ADDR+1)'(BINS);
    localparam logic [SW-1:0]       N_BEATS   = SW'(N_SAMPLES);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

    if (FW > RAM_ADDR || FW < 1) begin : g_bad_widths
        $error("sifh_ctrl: NP-RAM_ADDR must lie in 1..RAM_ADDR");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, HIST, PEAK} state_t;

    state_t              state;
    logic                pass2;
    logic [SW-1:0]       beat_cnt;
    logic [1:0]          drain;
    logic [RAM_ADDR-1:0] coarse_peak;
    logic                vld_p0, vld_p1;
    logic [RAM_ADDR-1:0] bin_p0, bin_p1;
    logic [RAM_ADDR-1:0] waddr_p2;
    logic [CNT_W-1:0]    wdata_p2;
    logic [RAM_ADDR:0]   rd_cnt;
    logic [CNT_W-1:0]    max_cnt;
    logic [RAM_ADDR-1:0] max_idx;

    logic [RAM_ADDR-1:0] coarse_in, bin_in, pk_idx, fin_idx;
    logic [CNT_W-1:0]    operand, fin_cnt;
    logic                beat, in_win, pk_upd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // The RAM read is read-first and the increment is registered, so a bin's latest
    // value may still sit in either of the last two write beats rather than in counts.
    always_comb begin
        coarse_in = data[NP-1 -: RAM_ADDR];
        bin_in    = pass2 ? RAM_ADDR'(data[FW-1:0]) : coarse_in;
        in_win    = !pass2 || (coarse_in == coarse_peak);
        beat      = (state == HIST) && data_valid && (beat_cnt != N_BEATS);
        operand   = counts;
        if (bin_p1 == waddr)
            operand = newCounts;
        else if (bin_p1 == waddr_p2)
            operand = wdata_p2;
        pk_idx  = rd_cnt[RAM_ADDR-1:0] - RAM_ADDR'(1);
        pk_upd  = (rd_cnt != '0) && (counts > max_cnt);
        fin_cnt = pk_upd ? counts : max_cnt;
        fin_idx = pk_upd ? pk_idx : max_idx;
    end

    always_ff @(posedge clk) begin
        // p0: bin whose read is on the RAM port; p1: its count is back; p2: last write beat
        bin_p0   <= bin_in;
        bin_p1   <= bin_p0;
        waddr_p2 <= waddr;
        wdata_p2 <= newCounts;
        if (res) begin
            state       <= IDLE;
            pass2       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            peak_count  <= '0;
            waddr       <= '0;
            raddr       <= '0;
            newCounts   <= '0;
            wEnable     <= 1'b0;
            rEnable     <= 1'b1;
            writeFlag   <= 1'b0;
            readFlag    <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            beat_cnt    <= '0;
            drain       <= '0;
            coarse_peak <= '0;
            rd_cnt      <= '0;
            max_cnt     <= '0;
            max_idx     <= '0;
        end else begin
            done   <= 1'b0;
            vld_p0 <= beat && in_win;
            vld_p1 <= vld_p0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        pass2     <= 1'b0;
                        busy      <= 1'b1;
                        waddr     <= '0;
                        newCounts <= '0;
                        wEnable   <= 1'b1;
                        writeFlag <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (waddr == LAST_ADDR) begin
                        state     <= HIST;
                        wEnable   <= 1'b0;
                        writeFlag <= 1'b0;
                        beat_cnt  <= '0;
                        drain     <= '0;
                    end else begin
                        waddr <= waddr + RAM_ADDR'(1);
                    end
                end
                HIST: begin
                    if (beat)
                        beat_cnt <= beat_cnt + SW'(1);
                    if (beat && in_win)
                        raddr <= bin_in;
                    readFlag <= beat && in_win;
                    rEnable  <= !(beat && in_win);
                    if (vld_p1) begin
                        waddr     <= bin_p1;
                        newCounts <= sat_inc(operand);
                        wEnable   <= 1'b1;
                        writeFlag <= 1'b1;
                    end else begin
                        wEnable   <= 1'b0;
                        writeFlag <= 1'b0;
                    end
                    if (beat_cnt == N_BEATS) begin
                        if (drain == 2'd2) begin
                            state    <= PEAK;
                            raddr    <= '0;
                            readFlag <= 1'b1;
                            rEnable  <= 1'b0;
                            rd_cnt   <= '0;
                            max_cnt  <= '0;
                            max_idx  <= '0;
                        end else begin
                            drain <= drain + 2'd1;
                        end
                    end
                end
                PEAK: begin
                    rd_cnt  <= rd_cnt + (RAM_ADDR+1)'(1);
                    max_cnt <= fin_cnt;
                    max_idx <= fin_idx;
                    if (rd_cnt < RD_LAST) begin
                        raddr <= raddr + RAM_ADDR'(1);
                    end else begin
                        readFlag <= 1'b0;
                        rEnable  <= 1'b1;
                    end
                    if (rd_cnt == RD_END) begin
                        if (!pass2) begin
                            coarse_peak <= fin_idx;
                            pass2       <= 1'b1;
                            state       <= CLEAR;
                            waddr       <= '0;
                            newCounts   <= '0;
                            wEnable     <= 1'b1;
                            writeFlag   <= 1'b1;
                        end else begin
                            result     <= {coarse_peak, fin_idx[FW-1:0]};
                            peak_count <= fin_cnt;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            pass2      <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sifh_ctrl.sv
// Directed bench for sifh_ctrl: default instance plus a 4-bit-count, 20-sample instance,
// each with its own read-first dual-port RAM model.
module tb_sifh_ctrl;

    localparam int NP = 10;
    localparam int RA = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, start_a, start_b, data_valid;
    logic [NP-1:0] data;

    logic [7:0]    cnt_a, nc_a, pc_a;
    logic [RA-1:0] wa_a, ra_a;
    logic          we_a, re_a, wf_a, rf_a, busy_a, done_a;
    logic [NP-1:0] res_a;

    logic [3:0]    cnt_b, nc_b, pc_b;
    logic [RA-1:0] wa_b, ra_b;
    logic          we_b, re_b, wf_b, rf_b, busy_b, done_b;
    logic [NP-1:0] res_b;

    sifh_ctrl dut_a (
        .clk(clk), .res(res), .start(start_a), .data_valid(data_valid), .data(data),
        .counts(cnt_a), .waddr(wa_a), .raddr(ra_a), .wEnable(we_a), .rEnable(re_a),
        .writeFlag(wf_a), .readFlag(rf_a), .newCounts(nc_a), .busy(busy_a),
        .done(done_a), .result(res_a), .peak_count(pc_a)
    );

    sifh_ctrl #(.CNT_W(4), .N_SAMPLES(20)) dut_b (
        .clk(clk), .res(res), .start(start_b), .data_valid(data_valid), .data(data),
        .counts(cnt_b), .waddr(wa_b), .raddr(ra_b), .wEnable(we_b), .rEnable(re_b),
        .writeFlag(wf_b), .readFlag(rf_b), .newCounts(nc_b), .busy(busy_b),
        .done(done_b), .result(res_b), .peak_count(pc_b)
    );

    logic [7:0] mem_a [64];
    logic [3:0] mem_b [64];

    always @(posedge clk) begin
        if (wf_a && we_a) mem_a[wa_a] <= nc_a;
        if (rf_a && !re_a) cnt_a <= mem_a[ra_a];
        if (wf_b && we_b) mem_b[wa_b] <= nc_b;
        if (rf_b && !re_b) cnt_b <= mem_b[ra_b];
    end

    int            sel;
    logic          o_busy, o_done, o_wf, o_we, o_rf, o_re;
    logic [RA-1:0] o_wa, o_ra;
    logic [7:0]    o_nc, o_pc;
    logic [NP-1:0] o_res;

    always_comb begin
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a; o_wf = wf_a; o_we = we_a;
            o_rf = rf_a; o_re = re_a; o_wa = wa_a; o_ra = ra_a;
            o_nc = nc_a; o_pc = pc_a; o_res = res_a;
        end else begin
            o_busy = busy_b; o_done = done_b; o_wf = wf_b; o_we = we_b;
            o_rf = rf_b; o_re = re_b; o_wa = wa_b; o_ra = ra_b;
            o_nc = {4'b0, nc_b}; o_pc = {4'b0, pc_b}; o_res = res_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_res"},   o_res,  0);
        chk({tag, "_pc"},    o_pc,   0);
        chk({tag, "_waddr"}, o_wa,   0);
        chk({tag, "_raddr"}, o_ra,   0);
        chk({tag, "_nc"},    o_nc,   0);
        chk({tag, "_wen"},   o_we,   0);
        chk({tag, "_ren"},   o_re,   1);
        chk({tag, "_wflag"}, o_wf,   0);
        chk({tag, "_rflag"}, o_rf,   0);
    endtask

    logic [NP-1:0] v1 [20];
    logic [NP-1:0] v2 [20];

    // Wait (bounded) for the final CLEAR write, which marks the next cycle as HIST.
    task automatic wait_clear_end(input string tag, output logic found);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (o_wf && o_we && o_wa == 6'd63 && o_nc == 8'd0) found = 1'b1;
        end
        chk({tag, "_clr_end"}, found, 1);
    endtask

    task automatic run(input string tag, input int n, input logic [NP-1:0] exp_res,
                       input logic [7:0] exp_pc);
        logic found;
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        @(negedge clk);
        chk({tag, "_busy_on"}, o_busy, 1);
        for (int p = 0; p < 2; p++) begin
            data_valid = 1'b1;
            data       = 10'h3FF;
            wait_clear_end(tag, found);
            @(posedge clk);
            for (int i = 0; i < n; i++) begin
                #1;
                data_valid = 1'b1;
                data       = (p == 0) ? v1[i] : v2[i];
                set_start(p == 1 && i == 3);
                @(posedge clk);
            end
            #1 data_valid = 1'b0;
            set_start(1'b0);
        end
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (o_done) found = 1'b1;
        end
        chk({tag, "_done_seen"}, found, 1);
        if (found) begin
            chk({tag, "_result"}, o_res, exp_res);
            chk({tag, "_peak"},   o_pc,  exp_pc);
            @(negedge clk);
            chk({tag, "_done_pulse"}, o_done, 0);
            chk({tag, "_busy_off"},   o_busy, 0);
            chk({tag, "_idle_wen"},   o_we,   0);
            chk({tag, "_idle_ren"},   o_re,   1);
            chk({tag, "_idle_wf"},    o_wf,   0);
            chk({tag, "_idle_rf"},    o_rf,   0);
            chk({tag, "_hold_res"},   o_res,  exp_res);
        end
    endtask

    initial begin
        logic found;
        res = 1'b1; start_a = 1'b0; start_b = 1'b0;
        data_valid = 1'b0; data = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        chk_reset("rst");

        // Same bin every beat: forwarding must keep all 16 increments.
        for (int i = 0; i < 16; i++) begin v1[i] = 10'h1A5; v2[i] = 10'h1A5; end
        run("b2b", 16, 10'h1A5, 8'd16);

        // Coarse tie 40 vs 3 goes to bin 3; fine pass alternates two bins plus outsiders.
        for (int i = 0; i < 8; i++) begin v1[i] = 10'h287; v1[i+8] = 10'h035; end
        v2[0] = 10'h037; v2[1] = 10'h03A; v2[2] = 10'h037; v2[3] = 10'h03A;
        v2[4] = 10'h037; v2[5] = 10'h03A; v2[6] = 10'h037; v2[7] = 10'h037;
        for (int i = 8; i < 16; i++) v2[i] = 10'h287;
        run("tie", 16, 10'h037, 8'd5);

        // Empty fine pass.
        for (int i = 0; i < 16; i++) begin v1[i] = 10'h1A5; v2[i] = 10'h0F0; end
        run("empty", 16, 10'h1A0, 8'd0);

        // Abort mid-HIST(1), then a clean run must not see the leftover counts.
        for (int i = 0; i < 16; i++) begin v1[i] = 10'h1A5; v2[i] = 10'h1A5; end
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_clear_end("abort", found);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 data_valid = 1'b1; data = 10'h1A5;
            @(posedge clk);
        end
        #1 res = 1'b1; data_valid = 1'b0;
        @(posedge clk); #1 res = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        run("after_rst", 16, 10'h1A5, 8'd16);

        // Narrow counters saturate at 15.
        sel = 1;
        for (int i = 0; i < 20; i++) begin v1[i] = 10'h040; v2[i] = 10'h040; end
        run("sat", 20, 10'h040, 8'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sifh_ctrl.md
SIFH_CTRL -- requirements
Module: sifh_ctrl

Interface
REQ-001 Parameter NP, default 10: timestamp width in bits.
REQ-002 Parameter RAM_ADDR, default 6: histogram RAM address width, giving 2^RAM_ADDR bins.
REQ-003 Parameter CNT_W, default 8: bin count width in bits.
REQ-004 Parameter N_SAMPLES, default 16: number of data_valid beats accepted per histogram pass.
REQ-005 The design SHALL require NP-RAM_ADDR <= RAM_ADDR; this is checked at elaboration.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 res  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  begin a measurement; sampled only in IDLE.
REQ-009 data_valid  in  1  data carries a timestamp this cycle.
REQ-010 data  in  NP  TDC timestamp.
REQ-011 counts  in  CNT_W  RAM port-b read data; 1-cycle latency; read-first on same-address collision.
REQ-012 waddr  out  RAM_ADDR  RAM port-a write address.
REQ-013 raddr  out  RAM_ADDR  RAM port-b read address.
REQ-014 wEnable  out  1  write enable, 1 = write.
REQ-015 rEnable  out  1  read enable, 0 = read.
REQ-016 writeFlag  out  1  port-a memory enable.
REQ-017 readFlag  out  1  port-b memory enable.
REQ-018 newCounts  out  CNT_W  RAM port-a write data.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse when result is valid.
REQ-021 result  out  NP  peak timestamp {coarse_peak, fine_peak}.
REQ-022 peak_count  out  CNT_W  count of the fine peak bin.

Function
REQ-023 The FSM SHALL have states IDLE, CLEAR, HIST, PEAK and a pass flag (1 or 2); the flow is IDLE -start-> CLEAR(1) -> HIST(1) -> PEAK(1) -> CLEAR(2) -> HIST(2) -> PEAK(2) -> IDLE.
REQ-024 CLEAR SHALL write 0 to addresses 0 .. 2^RAM_ADDR-1, one per cycle, taking exactly 2^RAM_ADDR cycles.
REQ-025 In HIST pass 1, bin = data[NP-1 -: RAM_ADDR].
REQ-026 In HIST pass 2, a sample is binned only if data[NP-1 -: RAM_ADDR] equals coarse_peak; its bin = zero-extended data[NP-RAM_ADDR-1:0].
REQ-027 Out-of-window samples in pass 2 SHALL still count toward N_SAMPLES.
REQ-028 HIST SHALL accept one sample per cycle: read at cycle t, write newCounts = counts+1 at cycle t+1.
REQ-029 Increment SHALL saturate at 2^CNT_W-1.
REQ-030 Forwarding: if the bin at t+1 equals the address written at t, the operand SHALL be the last newCounts, not counts, so back-to-back same-bin samples are never lost.
REQ-031 HIST SHALL exit to PEAK 2 cycles after the N_SAMPLES-th beat, once the pipeline has drained.
REQ-032 data_valid outside HIST SHALL be ignored.
REQ-033 PEAK SHALL read addresses 0 .. 2^RAM_ADDR-1 sequentially, lasting 2^RAM_ADDR+1 cycles.
REQ-034 PEAK SHALL track the maximum using strict greater-than, so the lowest index wins ties.
REQ-035 PEAK(1) SHALL latch coarse_peak.
REQ-036 PEAK(2) SHALL set result = {coarse_peak, fine_peak} and peak_count, then pulse done for one cycle on return to IDLE.
REQ-037 If pass 2 is empty, the result SHALL be result = {coarse_peak, 0} and peak_count = 0.
REQ-038 result and peak_count SHALL hold until the next done.
REQ-039 start while busy SHALL be ignored.
REQ-040 When not accessing memory, wEnable=0, rEnable=1, writeFlag=0, readFlag=0.

Reset
REQ-041 With res high at a clock edge, the next cycle SHALL have: state IDLE, pass 1, busy=0, done=0, result=0, peak_count=0, waddr=0, raddr=0, newCounts=0, wEnable=0, rEnable=1, writeFlag=0, readFlag=0, pipeline cleared.
REQ-042 Reset mid-operation SHALL abort the run; RAM contents are left as they are, and the next run's CLEAR removes them.

Verification (defaults unless stated)
REQ-043 16 back-to-back beats of data=10'h1A5 -> coarse_peak=26; done with result=10'h1A5, peak_count=16 (exercises forwarding).
REQ-044 CNT_W=4, N_SAMPLES=20, all beats data=10'h040 -> peak_count=15 (saturated), result=10'h040.
REQ-045 Pass 1: 8 beats in bin 40, then 8 beats in bin 3 -> coarse_peak=3 (tie goes to the lower index).
REQ-046 Pass 2: all 16 beats outside the window -> result={coarse_peak,4'h0}, peak_count=0.
REQ-047 res asserted mid-HIST(1) -> all outputs at reset values the next cycle; a fresh start then produces the correct result; a start pulse while busy has no effect.
